muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / restoring divide, one bit per cycle.
// Divider datapath is built only when MULDIV_DIVIDER_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             illegal
);

`ifdef MULDIV_DIVIDER_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state;
  logic [CNTW-1:0]  cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic             fin;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;

  always_comb begin
    sgn    = ~op[0];
    a_neg  = sgn & a[WIDTH-1];
    b_neg  = sgn & b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    b_zero = (b == '0);
  end

  logic [WIDTH:0]   m_sum;
  logic [WIDTH-1:0] s_hi;
  logic [WIDTH-1:0] s_lo;

`ifdef MULDIV_DIVIDER_EN
  logic [WIDTH:0]   d_sh;
  logic [WIDTH:0]   d_diff;
`endif

  // p_lo holds multiplier / dividend bits, p_hi the partial product / remainder
  always_comb begin
    m_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, d_q} : '0);
    s_hi  = m_sum[WIDTH:1];
    s_lo  = {m_sum[0], p_lo[WIDTH-1:1]};
`ifdef MULDIV_DIVIDER_EN
    d_sh   = {p_hi, p_lo[WIDTH-1]};
    d_diff = d_sh - {1'b0, d_q};
    if (is_div) begin
      if (!d_diff[WIDTH]) begin
        s_hi = d_diff[WIDTH-1:0];
        s_lo = {p_lo[WIDTH-2:0], 1'b1};
      end else begin
        s_hi = d_sh[WIDTH-1:0];
        s_lo = {p_lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   f_hi;
  logic [WIDTH-1:0]   f_lo;

  always_comb begin
    prod = {p_hi, p_lo};
    f_hi = p_hi;
    f_lo = p_lo;
    if (dz) begin
      f_hi = a_q;
      f_lo = '1;
    end else if (is_div) begin
      if (neg_q) f_lo = -p_lo;
      if (neg_r) f_hi = -p_hi;
    end else if (neg_q) begin
      {f_hi, f_lo} = -prod;
    end
  end

  assign busy = (state != IDLE);

  // fin marks the commit cycle: results reach hi/lo together with done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      fin         <= 1'b0;
      a_q         <= '0;
      d_q         <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (fin) begin
        hi          <= p_hi;
        lo          <= p_lo;
        done        <= 1'b1;
        div_by_zero <= dz;
        fin         <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start && !fin) begin
            if (op[1] && !DIV_EN) begin
              illegal <= 1'b1;
            end else begin
              is_div      <= op[1];
              a_q         <= a;
              d_q         <= b_mag;
              p_hi        <= '0;
              p_lo        <= a_mag;
              neg_q       <= a_neg ^ b_neg;
              neg_r       <= a_neg;
              dz          <= op[1] & b_zero;
              div_by_zero <= 1'b0;
              cnt         <= CNTW'(WIDTH);
              state       <= (op[1] && b_zero) ? FIX : CALC;
            end
          end
        end
        CALC: begin
          p_hi <= s_hi;
          p_lo <= s_lo;
          cnt  <= cnt - 1'b1;
          if (cnt == CNTW'(1)) state <= FIX;
        end
        FIX: begin
          p_hi  <= f_hi;
          p_lo  <= f_lo;
          fin   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit (WIDTH=32).
// Divide ops expect results with MULDIV_DIVIDER_EN, illegal pulses otherwise.
module tb_muldiv_unit;
  localparam int W  = 32;
  localparam int CW = $clog2(W) + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;
  logic         illegal;

  muldiv_unit #(.WIDTH(W), .CNTW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo),
    .div_by_zero(div_by_zero),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           ill;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           dz;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  bit           last_dz = 1'b0;
  logic [W-1:0] held_hi = '0;
  logic [W-1:0] held_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t            e;
    longint          sx, sy, p;
    longint unsigned ux, uy, up;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    ux    = 64'(x);
    uy    = 64'(y);
    e.ill = 1'b0;
    e.dz  = 1'b0;
    e.cyc = W + 2;
    e.hi  = '0;
    e.lo  = '0;
`ifndef MULDIV_DIVIDER_EN
    if (o[1]) begin
      e.ill = 1'b1;
      e.hi  = last_hi;
      e.lo  = last_lo;
      e.dz  = last_dz;
      e.cyc = 0;
      return e;
    end
`endif
    case (o)
      2'd0: begin
        p = sx * sy;
        {e.hi, e.lo} = p;
      end
      2'd1: begin
        up = ux * uy;
        {e.hi, e.lo} = up;
      end
      default: begin
        if (y == '0) begin
          e.hi  = x;
          e.lo  = '1;
          e.dz  = 1'b1;
          e.cyc = 2;
        end else if (o == 2'd2) begin
          e.lo = W'(sx / sy);
          e.hi = W'(sx % sy);
        end else begin
          e.lo = W'(ux / uy);
          e.hi = W'(ux % uy);
        end
      end
    endcase
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      4: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // monitor: pops the scoreboard on every done/illegal pulse
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      held_hi = '0;
      held_lo = '0;
    end else if (done || illegal) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'({done, illegal}), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("kind", 64'({done, illegal}), e.ill ? 64'(1) : 64'(2));
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        chk("busy_at_out", 64'(busy), 64'(0));
        held_hi = e.hi;
        held_lo = e.lo;
      end
    end else begin
      chk("hold_hi", 64'(hi), 64'(held_hi));
      chk("hold_lo", 64'(lo), 64'(held_lo));
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input bit noise);
    exp_t e;
    int   t;
    e     = model(o, x, y);
    e.cyc = e.cyc + cyc + 1;
    q.push_back(e);
    if (!e.ill) begin
      last_hi = e.hi;
      last_lo = e.lo;
      last_dz = e.dz;
    end
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = W'($urandom);
    b     = W'($urandom);
    t     = 0;
    while (!(done || illegal) && t < 100) begin
      start = noise && !e.ill && (t == 8);
      @(posedge clk);
      #1;
      t++;
    end
    start = 1'b0;
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done after %0d cycles, required one", t);
      q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_illegal", 64'(illegal), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    rst_n = 1'b1;

    issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(2'd3, 32'd5, 32'd0, 1'b0);
    issue(2'd1, 32'd3, 32'd4, 1'b0);
    issue(2'd2, 32'h8000_0000, 32'd0, 1'b0);
    issue(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(2'd3, 32'h1234_5678, 32'h0000_0010, 1'b0);

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom), pick(), pick(), 1'($urandom));
    end

    issue(2'd0, 32'd123, 32'd456, 1'b0);

    // abort: start, ignored start at cycle 10, reset at cycle 20
    start = 1'b1;
    op    = 2'd0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0000_1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("busy_before_rst", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    q.delete();
    last_hi = '0;
    last_lo = '0;
    last_dz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (W + 6) @(posedge clk);
    #1;
    chk("idle_after_abort", 64'(busy), 64'(0));

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(2'd1, 32'hCAFE_F00D, 32'h0000_0003, 1'b0);
    issue(2'd2, 32'd100, 32'hFFFF_FFF9, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
